// File: rtl/transmissor_16.sv
// UART transmitter: sends a 2*N_BITS word as two back-to-back frames, high half first.
// Define TRANSMISSOR_16_STOP2_EN for two stop bits per frame (default is one).
module transmissor_16 #(
    parameter int BAUD_RATE = 115200,
    parameter int CLOCK_HZ  = 50_000_000,
    parameter int N_BITS    = 8,
    parameter int PARITY    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  partida,
    input  logic [2*N_BITS-1:0]   data_in,
    output logic                  tx_serial,
    output logic                  ocupado,
    output logic                  pronto
);

    localparam int T = CLOCK_HZ / BAUD_RATE;
`ifdef TRANSMISSOR_16_STOP2_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif
    localparam int PAR_BITS  = (PARITY != 0) ? 1 : 0;
    localparam int FRAME_LEN = 1 + N_BITS + PAR_BITS + STOP_BITS;
    localparam int BAUD_W    = $clog2(T + 1);
    localparam int BIT_W     = $clog2(FRAME_LEN + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(T - 1);
    localparam logic [BAUD_W-1:0] BAUD_PENULT = BAUD_W'(T - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {INICIAL, ALTO, BAIXO, FINAL} state_t;

    function automatic logic parity_bit(input logic [N_BITS-1:0] d);
        return (PARITY == 2) ? ~^d : ^d;
    endfunction

    // Whole frame in transmit order, bit 0 goes on the line first.
    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [N_BITS-1:0] d);
        logic [FRAME_LEN-1:0] f;
        f           = '1;
        f[0]        = 1'b0;
        f[N_BITS:1] = d;
        if (PAR_BITS != 0)
            f[N_BITS+1] = parity_bit(d);
        return f;
    endfunction

    state_t               state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [FRAME_LEN-1:0] shreg;
    logic [N_BITS-1:0]    low_half;

    logic [FRAME_LEN-1:0] frame_hi;
    logic [FRAME_LEN-1:0] frame_lo;
    logic                 accept;
    logic                 bit_end;
    logic                 frame_end;
    logic                 last_cycle;

    assign frame_hi  = build_frame(data_in[2*N_BITS-1:N_BITS]);
    assign frame_lo  = build_frame(low_half);
    assign accept    = ((state == INICIAL) || (state == FINAL)) && partida;
    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign frame_end = bit_end && (bit_cnt == BIT_LAST);
    // The final cycle of the low stop bit is spent in FINAL, so BAIXO leaves one cycle early.
    assign last_cycle = (state == BAIXO) && (bit_cnt == BIT_LAST) && (baud_cnt == BAUD_PENULT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= INICIAL;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            tx_serial <= 1'b1;
            ocupado   <= 1'b0;
            pronto    <= 1'b0;
        end else begin
            unique case (state)
                INICIAL, FINAL: begin
                    pronto   <= 1'b0;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (partida) begin
                        state     <= ALTO;
                        tx_serial <= 1'b0;
                        ocupado   <= 1'b1;
                    end else begin
                        state     <= INICIAL;
                        tx_serial <= 1'b1;
                        ocupado   <= 1'b0;
                    end
                end
                ALTO: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state     <= BAIXO;
                            bit_cnt   <= '0;
                            tx_serial <= 1'b0;
                        end else begin
                            bit_cnt   <= bit_cnt + BIT_W'(1);
                            tx_serial <= shreg[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                BAIXO: begin
                    if (last_cycle) begin
                        state     <= FINAL;
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                        tx_serial <= 1'b1;
                        ocupado   <= 1'b0;
                        pronto    <= 1'b1;
                    end else if (bit_end) begin
                        baud_cnt  <= '0;
                        bit_cnt   <= bit_cnt + BIT_W'(1);
                        tx_serial <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: state <= INICIAL;
            endcase
        end
    end

    // Shift register holds the bits still to be sent; shifted-in ones pad the stop level.
    always_ff @(posedge clock) begin
        if (accept) begin
            shreg    <= {1'b1, frame_hi[FRAME_LEN-1:1]};
            low_half <= data_in[N_BITS-1:0];
        end else if ((state == ALTO) && frame_end) begin
            shreg <= {1'b1, frame_lo[FRAME_LEN-1:1]};
        end else if (((state == ALTO) || (state == BAIXO)) && bit_end) begin
            shreg <= {1'b1, shreg[FRAME_LEN-1:1]};
        end
    end

endmodule

// File: tb/tb_transmissor_16.sv
// Bench for transmissor_16: four instances (even/odd/no parity at T=16, defaults at T=434)
// checked every cycle against a bit-stream model, plus hand-computed decode and timing literals.
module tb_transmissor_16;

    localparam int NI = 4;
`ifdef TRANSMISSOR_16_STOP2_EN
    localparam int NSTOP   = 2;
    localparam int PR16_P  = 384;
    localparam int PR16_N  = 352;
    localparam int PR_DFLT = 10416;
`else
    localparam int NSTOP   = 1;
    localparam int PR16_P  = 352;
    localparam int PR16_N  = 320;
    localparam int PR_DFLT = 9548;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [NI-1:0] rst_v;
    logic [NI-1:0] go_v;
    logic [15:0]   din [NI];
    logic [NI-1:0] tx_v;
    logic [NI-1:0] oc_v;
    logic [NI-1:0] pr_v;

    transmissor_16 #(.BAUD_RATE(1), .CLOCK_HZ(16), .N_BITS(8), .PARITY(1)) u_even (
        .clock(clock), .reset(rst_v[0]), .partida(go_v[0]), .data_in(din[0]),
        .tx_serial(tx_v[0]), .ocupado(oc_v[0]), .pronto(pr_v[0]));
    transmissor_16 #(.BAUD_RATE(1), .CLOCK_HZ(16), .N_BITS(8), .PARITY(2)) u_odd (
        .clock(clock), .reset(rst_v[1]), .partida(go_v[1]), .data_in(din[1]),
        .tx_serial(tx_v[1]), .ocupado(oc_v[1]), .pronto(pr_v[1]));
    transmissor_16 #(.BAUD_RATE(1), .CLOCK_HZ(16), .N_BITS(8), .PARITY(0)) u_none (
        .clock(clock), .reset(rst_v[2]), .partida(go_v[2]), .data_in(din[2]),
        .tx_serial(tx_v[2]), .ocupado(oc_v[2]), .pronto(pr_v[2]));
    transmissor_16 u_dflt (
        .clock(clock), .reset(rst_v[3]), .partida(go_v[3]), .data_in(din[3]),
        .tx_serial(tx_v[3]), .ocupado(oc_v[3]), .pronto(pr_v[3]));

    function automatic int tper(input int i);
        return (i == 3) ? 434 : 16;
    endfunction

    function automatic int ppar(input int i);
        case (i)
            1:       return 2;
            2:       return 0;
            default: return 1;
        endcase
    endfunction

    function automatic int flen(input int i);
        return 1 + 8 + ((ppar(i) != 0) ? 1 : 0) + NSTOP;
    endfunction

    function automatic int tlen(input int i);
        return 2 * flen(i) * tper(i);
    endfunction

    // Line level of bit k (0-based, across both frames) for a given word.
    function automatic logic exp_bit(input int i, input logic [15:0] w, input int k);
        int         fl, pos;
        logic [7:0] half;
        fl   = flen(i);
        pos  = k % fl;
        half = (k < fl) ? w[15:8] : w[7:0];
        if (pos == 0) return 1'b0;
        if (pos <= 8) return half[pos-1];
        if (pos == 9 && ppar(i) == 1) return ^half;
        if (pos == 9 && ppar(i) == 2) return ~^half;
        return 1'b1;
    endfunction

    bit          m_busy [NI];
    int          m_idx  [NI];
    logic [15:0] m_word [NI];
    logic [31:0] capv   [NI];
    int          pr_count [NI];
    int          checks = 0;
    int          fails  = 0;
    bit          armed  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_idx counts cycles since the accept edge; the word occupies cycles 1..tlen.
    always @(posedge clock) begin
        for (int i = 0; i < NI; i++) begin
            if (rst_v[i] === 1'b1) begin
                m_busy[i] = 1'b0;
                m_idx[i]  = 0;
            end else if ((!m_busy[i] || m_idx[i] == tlen(i)) && go_v[i] === 1'b1) begin
                m_busy[i] = 1'b1;
                m_idx[i]  = 1;
                m_word[i] = din[i];
            end else if (m_busy[i]) begin
                if (m_idx[i] == tlen(i)) begin
                    m_busy[i] = 1'b0;
                    m_idx[i]  = 0;
                end else begin
                    m_idx[i]++;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (armed) begin
            for (int i = 0; i < NI; i++) begin
                logic etx, eoc, epr;
                int   k;
                if (m_busy[i]) begin
                    k   = (m_idx[i] - 1) / tper(i);
                    etx = exp_bit(i, m_word[i], k);
                    eoc = (m_idx[i] < tlen(i));
                    epr = (m_idx[i] == tlen(i));
                    if (m_idx[i] == 1) capv[i] = '0;
                    if ((m_idx[i] - 1) % tper(i) == tper(i) / 2) capv[i][k] = tx_v[i];
                end else begin
                    etx = 1'b1;
                    eoc = 1'b0;
                    epr = 1'b0;
                end
                chk($sformatf("tx_serial[%0d]", i), 32'(tx_v[i]), 32'(etx));
                chk($sformatf("ocupado[%0d]", i), 32'(oc_v[i]), 32'(eoc));
                chk($sformatf("pronto[%0d]", i), 32'(pr_v[i]), 32'(epr));
                if (pr_v[i] === 1'b1) pr_count[i]++;
            end
        end
    end

    // Receiver-style decode of the mid-bit samples of the last word.
    task automatic decode(input int i, output logic [15:0] w, output logic ph, output logic pl,
                          output logic ferr);
        int          fl;
        logic [31:0] c;
        fl = flen(i);
        c  = capv[i];
        for (int b = 0; b < 8; b++) begin
            w[8+b] = c[1+b];
            w[b]   = c[fl+1+b];
        end
        ph   = c[9];
        pl   = c[fl+9];
        ferr = c[0] | c[fl];
        for (int s = 0; s < NSTOP; s++)
            ferr = ferr | ~c[fl-1-s] | ~c[2*fl-1-s];
    endtask

    task automatic start(input int i, input logic [15:0] w);
        @(negedge clock);
        din[i]  = w;
        go_v[i] = 1'b1;
        @(negedge clock);
        go_v[i] = 1'b0;
    endtask

    task automatic wait_pronto(input int i, input int budget, output int n);
        n = 1;
        while (pr_v[i] !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
    endtask

    initial begin
        int          n;
        int          base;
        logic [15:0] w;
        logic        ph, pl, ferr;

        rst_v = '1;
        go_v  = '0;
        for (int i = 0; i < NI; i++) begin
            din[i]      = 16'h8001;
            pr_count[i] = 0;
            capv[i]     = '0;
        end
        @(posedge clock);
        armed = 1'b1;
        repeat (3) @(negedge clock);
        rst_v = '0;

        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            chk("idle_tx", 32'(tx_v[0]), 32'd1);
            chk("idle_ocupado", 32'(oc_v[0]), 32'd0);
            chk("idle_pronto", 32'(pr_v[0]), 32'd0);
        end

        start(0, 16'h8001);
        wait_pronto(0, 1000, n);
        chk("basic_pronto_cycle", n, PR16_P);
        decode(0, w, ph, pl, ferr);
        chk("basic_word", w, 16'h8001);
        chk("basic_par_hi", 32'(ph), 32'd1);
        chk("basic_par_lo", 32'(pl), 32'd1);
        chk("basic_frame_err", 32'(ferr), 32'd0);

        start(0, 16'h8001);
        repeat (50) @(negedge clock);
        din[0]  = 16'hFFFF;
        go_v[0] = 1'b1;
        @(negedge clock);
        go_v[0] = 1'b0;
        wait_pronto(0, 1000, n);
        chk("busy_pronto_cycle", n, PR16_P - 51);
        decode(0, w, ph, pl, ferr);
        chk("busy_word", w, 16'h8001);

        din[0]  = 16'h1234;
        go_v[0] = 1'b1;
        @(negedge clock);
        go_v[0] = 1'b0;
        chk("b2b_start_tx", 32'(tx_v[0]), 32'd0);
        chk("b2b_start_ocupado", 32'(oc_v[0]), 32'd1);
        wait_pronto(0, 1000, n);
        chk("b2b_pronto_cycle", n, PR16_P);
        decode(0, w, ph, pl, ferr);
        chk("b2b_word", w, 16'h1234);
        chk("b2b_par_hi", 32'(ph), 32'd0);
        chk("b2b_par_lo", 32'(pl), 32'd1);

        start(0, 16'h5A3C);
        repeat (98) @(negedge clock);
        rst_v[0] = 1'b1;
        @(negedge clock);
        rst_v[0] = 1'b0;
        chk("abort_tx", 32'(tx_v[0]), 32'd1);
        chk("abort_ocupado", 32'(oc_v[0]), 32'd0);
        base = pr_count[0];
        repeat (400) @(negedge clock);
        chk("abort_no_pronto", pr_count[0] - base, 0);
        start(0, 16'h1234);
        wait_pronto(0, 1000, n);
        chk("after_abort_pronto_cycle", n, PR16_P);
        decode(0, w, ph, pl, ferr);
        chk("after_abort_word", w, 16'h1234);

        start(1, 16'hA53C);
        wait_pronto(1, 1000, n);
        chk("odd_pronto_cycle", n, PR16_P);
        decode(1, w, ph, pl, ferr);
        chk("odd_word", w, 16'hA53C);
        chk("odd_par_hi", 32'(ph), 32'd1);
        chk("odd_par_lo", 32'(pl), 32'd1);
        chk("odd_frame_err", 32'(ferr), 32'd0);

        start(2, 16'hA53C);
        wait_pronto(2, 1000, n);
        chk("nopar_pronto_cycle", n, PR16_N);
        decode(2, w, ph, pl, ferr);
        chk("nopar_word", w, 16'hA53C);
        chk("nopar_frame_err", 32'(ferr), 32'd0);

        start(3, 16'hBEEF);
        wait_pronto(3, 20000, n);
        chk("dflt_pronto_cycle", n, PR_DFLT);
        decode(3, w, ph, pl, ferr);
        chk("dflt_word", w, 16'hBEEF);
        chk("dflt_par_hi", 32'(ph), 32'd0);
        chk("dflt_par_lo", 32'(pl), 32'd1);
        chk("dflt_frame_err", 32'(ferr), 32'd0);

        repeat (5) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/transmissor_16.md
Name: transmissor_16

Overview:
- Serial UART transmitter that sends one 2*N_BITS-bit word as two consecutive asynchronous frames: high half first, then low half.
- It is the transmit counterpart of the 16-bit receiver and uses the identical frame format, so the two interoperate directly.
- Built as a control unit (FSM) plus a datapath (baud counter, bit counter, shift register, parity generator).

Parameters:
- BAUD_RATE, 115200, serial bit rate in bits/s.
- CLOCK_HZ, 50_000_000, clock frequency in Hz. Bit period T = CLOCK_HZ/BAUD_RATE (integer division, truncated). T >= 2 is required.
- N_BITS, 8, data bits per frame. Word width is 2*N_BITS.
- PARITY, 1, parity mode: 0 = no parity bit, 1 = even parity, 2 = odd parity.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- partida  input  1  start request, sampled on the rising edge.
- data_in  input  2*N_BITS  word to send. Latched when a start is accepted.
- tx_serial  output  1  serial line. Idle level is 1.
- ocupado  output  1  high while a transmission is in progress.
- pronto  output  1  one-cycle pulse when the word has been fully sent.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: tx_serial=1, ocupado=0, pronto=0, FSM in INICIAL, all counters at 0.
- Reset mid-operation: the transmission is aborted. tx_serial=1 and ocupado=0 starting the cycle after the reset edge. Any partial frame is simply truncated, with no recovery.
- Frame format:
  - start bit 0
  - N_BITS data bits, LSB first
  - parity bit, only if PARITY!=0, computed over that frame's N_BITS
  - one stop bit 1
- Bit timing: every bit is held on tx_serial for exactly T cycles. All outputs are registered.
- Frame order: high frame (data_in[2N-1:N]) immediately followed by low frame (data_in[N-1:0]). There is no idle gap between them.
- Total transmission length: 2*(N_BITS+2+(PARITY!=0))*T cycles. With defaults: 22*434 = 9548 cycles.
- FSM states:
  - INICIAL: idle, tx_serial=1. If partida=1, latch data_in and go to ALTO.
  - ALTO: shift out the high frame. After its stop bit's T cycles, go to BAIXO.
  - BAIXO: shift out the low frame. After its stop bit's T cycles, go to FINAL.
  - FINAL: pronto=1 and ocupado=0 for exactly one cycle, tx_serial=1. Then go to INICIAL.
- Start latency: on the edge where partida=1 is accepted, tx_serial becomes 0 and ocupado becomes 1 (both visible in the following cycle).
- Handshake rules:
  - partida is accepted only in INICIAL or FINAL.
  - If accepted in FINAL, the next start bit follows the pronto cycle directly, with no extra idle cycle.
  - partida while ocupado=1 is ignored.
  - Changes on data_in while ocupado=1 have no effect.
- Parity rules:
  - even: the parity bit makes the count of 1s in data+parity even.
  - odd: the parity bit makes that count odd.
- Simultaneous reset and partida: reset wins.

Optional Feature:
- Macro: TRANSMISSOR_16_STOP2_EN.
- Defined: each frame carries two stop bits (2*T cycles of 1). Total length becomes 2*(N_BITS+3+(PARITY!=0))*T cycles. Everything else is unchanged.
- Undefined: one stop bit per frame, as specified above.

Test Plan:
- Reset idle. Use CLOCK_HZ=16, BAUD_RATE=1 (T=16), PARITY=1, data_in=16'h8001. Hold reset for 3 cycles, then run 20 cycles with partida=0 -> tx_serial=1, ocupado=0, pronto=0 throughout.
- Basic word. Same parameters, pulse partida with data_in=16'h8001 -> tx_serial shows these bits, each exactly 16 cycles:
  - high frame: 0, 0,0,0,0,0,0,0,1, then parity 1, then stop 1
  - low frame: 0, 1,0,0,0,0,0,0,0, then parity 1, then stop 1
  - Then: pronto high for exactly 1 cycle at cycle 352 after the accept edge; ocupado high for cycles 1..351.
- Odd parity and no parity. PARITY=2 with data_in=16'hA53C -> both parity bits are 1. PARITY=0 -> frames are 10 bits and pronto arrives at cycle 320.
- Busy and back-to-back:
  - During the transmission, pulse partida again with data_in=16'hFFFF -> ignored; the original word is sent unchanged.
  - Assert partida in the pronto cycle with 16'h1234 -> a new start bit begins on the next cycle.
- Reset mid-frame: assert reset at cycle 100 of a transmission -> tx_serial=1 and ocupado=0 from the next cycle, pronto never pulses, and a new partida afterwards transmits correctly.
- Decode and option check: loop tx_serial into the receiver with defaults (T=434) and send 16'hBEEF -> the receiver reports data_out=16'hBEEF, erro=0. With TRANSMISSOR_16_STOP2_EN defined, the receiver still decodes correctly and pronto arrives at cycle 24*434.
